dmem_responder: RTL and testbench

- Data-memory responder that serves the load/store requests the RV32I core issues from its MEM stage.
- Replaces the zero-latency data memory with a ready/valid request/response interface. Adds configurable wait states, RV32I byte/half/word lane handling, sign/zero extension, and misalignment/range error reporting.
- Single outstanding transaction. `busy` stalls the pipeline while a request is pending.

---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// Adds wait states, RV32I byte/half/word lanes and error responses.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         cnt;
  logic                  lat_write;
  logic [2:0]            lat_f3;
  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  access;
  logic                  f3_bad;
  logic                  misal;
  logic                  oor;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rword;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [31:0]           ld_val;
  logic [3:0]            wmask;
  logic [31:0]           wbus;

  assign accept   = req_valid && req_ready;
  assign access   = (state == WAIT) && (cnt == '0);
  assign word_idx = lat_addr[ADDR_WIDTH+1:2];
  assign rword    = mem[word_idx];

  // Classify the incoming request so errors bypass the array entirely.
  always_comb begin
    if (req_write)
      f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010,
                                    3'b100, 3'b101});
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oor   = |req_addr[31:ADDR_WIDTH+2];
    req_err = f3_bad || misal || oor;
  end

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    ld_b = rword[{lat_addr[1:0], 3'b000} +: 8];
    ld_h = lat_addr[1] ? rword[31:16] : rword[15:0];
    unique case (lat_f3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_val = rword;
      3'b100:  ld_val = {24'h0, ld_b};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = '0;
    endcase
  end

  // Byte-enable mask and replicated store data per store width.
  always_comb begin
    unique case (1'b1)
      lat_f3[1:0] == 2'b00: begin
        wmask = 4'b0001 << lat_addr[1:0];
        wbus  = {4{lat_wdata[7:0]}};
      end
      lat_f3[1:0] == 2'b01: begin
        wmask = lat_addr[1] ? 4'b1100 : 4'b0011;
        wbus  = {2{lat_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wbus  = lat_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = req_err ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and stall outputs.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    busy       = (state != IDLE) || req_valid;
    resp_valid = (state == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Request capture, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_f3    <= req_funct3;
      lat_addr  <= req_addr[ADDR_WIDTH+1:0];
      lat_wdata <= req_wdata;
      cnt       <= CW'(WAIT_STATES);
      if (req_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        rdata_q <= lat_write ? 32'h0 : ld_val;
        err_q   <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage array; reset never clears it and never commits a store.
  always_ff @(posedge clk) begin
    if (access && lat_write && !rst) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wbus[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// DUT a uses WAIT_STATES=2, DUT b uses WAIT_STATES=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_ready = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  logic        req_ready_m, resp_valid_m, resp_err_m, busy_m;
  logic [31:0] resp_rdata_m;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  assign req_ready_m  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid_m = sel ? b_resp_valid : a_resp_valid;
  assign resp_err_m   = sel ? b_resp_err   : a_resp_err;
  assign resp_rdata_m = sel ? b_resp_rdata : a_resp_rdata;
  assign busy_m       = sel ? b_busy       : a_busy;

  // Drives one full transaction; lat = edges from acceptance to resp_valid.
  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic er);
    int n;
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_m && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid_m && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid_m) lat = -1;
    rd = resp_rdata_m; er = resp_err_m;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if (req_ready_m !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready got %b exp 0", req_ready_m);
    end
    n_chk++;
    if ({resp_valid_m, resp_err_m, busy_m} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got v%b e%b b%b exp 000",
               resp_valid_m, resp_err_m, busy_m);
    end
    n_chk++;
    if (resp_rdata_m !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata got %h exp 0", resp_rdata_m);
    end
    rst = 1'b0; #1;
    n_chk++;
    if ({a_req_ready, b_req_ready} !== 2'b11) begin
      n_fail++; $display("FAIL rst_release got %b%b exp 11",
                         a_req_ready, b_req_ready);
    end
    req_valid = 1'b1; #1;
    n_chk++;
    if (busy_m !== 1'b1) begin
      n_fail++; $display("FAIL idle_busy got %b exp 1", busy_m);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] rd; logic er;
    sel = 1'b0;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
    n_chk++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL sw_resp got lat%0d e%b %h exp lat3 e0 0",
                         lat, er, rd);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_chk++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_resp got lat%0d e%b %h exp lat3 e0 deadbeef",
                         lat, er, rd);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE,
                              32'hFFFFDEAD, 32'h0000BEEF};
    int lat; logic [31:0] rd; logic er;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er);
      n_chk++;
      if (rd !== exps[i] || er !== 1'b0) begin
        n_fail++; $display("FAIL ld_ext%0d got %h e%b exp %h", i, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic er;
    sel = 1'b0;
    do_req(1'b1, 3'b000, 32'h11, 32'h123456AA, lat, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_chk++;
    if (rd !== 32'hDEADAAEF) begin
      n_fail++; $display("FAIL sb_merge got %h exp deadaaef", rd);
    end
    do_req(1'b1, 3'b001, 32'h12, 32'h00007777, lat, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_chk++;
    if (rd !== 32'h7777AAEF) begin
      n_fail++; $display("FAIL sh_merge got %h exp 7777aaef", rd);
    end
  endtask

  task automatic test_errors();
    logic        ws  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ads [5] = '{32'h12, 32'h11, 32'h1000, 32'h10, 32'h10};
    int lat; logic [31:0] rd; logic er;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_req(ws[i], f3s[i], ads[i], 32'hFFFFFFFF, lat, rd, er);
      n_chk++;
      if (lat !== 0 || er !== 1'b1 || rd !== 32'h0) begin
        n_fail++; $display("FAIL err%0d got lat%0d e%b %h exp lat0 e1 0",
                           i, lat, er, rd);
      end
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_chk++;
    if (rd !== 32'h7777AAEF) begin
      n_fail++; $display("FAIL err_nowrite got %h exp 7777aaef", rd);
    end
  endtask

  task automatic test_backpressure();
    int n;
    sel = 1'b0;
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_m && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_funct3 = 3'b101; req_addr = 32'h12;
    n = 0;
    while (!resp_valid_m && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({resp_valid_m, req_ready_m, busy_m, resp_rdata_m} !==
          {1'b1, 1'b0, 1'b1, 32'h7777AAEF}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v%b r%b b%b %h exp v1 r0 b1 7777aaef",
                 i, resp_valid_m, req_ready_m, busy_m, resp_rdata_m);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_chk++;
    if ({resp_valid_m, req_ready_m} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release got v%b r%b exp v0 r1",
                         resp_valid_m, req_ready_m);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_chk++;
    if (req_ready_m !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept got r%b exp r0", req_ready_m);
    end
    n = 0;
    while (!resp_valid_m && n < 40) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (resp_rdata_m !== 32'h00007777 || resp_valid_m !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got v%b %h exp v1 00007777",
                         resp_valid_m, resp_rdata_m);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait(input logic s);
    int lat; int explat; int n; logic [31:0] rd; logic er;
    sel = s;
    explat = s ? 1 : 3;
    do_req(1'b1, 3'b010, 32'h20, 32'h11111111, lat, rd, er);
    n_chk++;
    if (lat !== explat || er !== 1'b0) begin
      n_fail++; $display("FAIL rw%0d_sw got lat%0d e%b exp lat%0d e0",
                         s, lat, er, explat);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    n_chk++;
    if (rd !== 32'h11111111) begin
      n_fail++; $display("FAIL rw%0d_lw got %h exp 11111111", s, rd);
    end
    req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_m && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1; #1;
    n_chk++;
    if ({resp_valid_m, req_ready_m} !== 2'b00) begin
      n_fail++; $display("FAIL rw%0d_wait got v%b r%b exp v0 r0",
                         s, resp_valid_m, req_ready_m);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({resp_valid_m, resp_err_m, resp_rdata_m} !== 34'h0) begin
      n_fail++; $display("FAIL rw%0d_clear got v%b e%b %h exp v0 e0 0",
                         s, resp_valid_m, resp_err_m, resp_rdata_m);
    end
    rst = 1'b0; #1;
    n_chk++;
    if (req_ready_m !== 1'b1) begin
      n_fail++; $display("FAIL rw%0d_idle got r%b exp r1", s, req_ready_m);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    n_chk++;
    if (rd !== 32'h11111111 || lat !== explat) begin
      n_fail++; $display("FAIL rw%0d_kept got %h lat%0d exp 11111111 lat%0d",
                         s, rd, lat, explat);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_reset_in_wait(1'b0);
    test_reset_in_wait(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
